// File: rtl/apb_master_arb.sv
// Two-requester APB master with round-robin arbitration and registered APB outputs.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master_arb #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_timeout_range
    $error("apb_master_arb: TIMEOUT_CYC must be in 2..255");
  end

  logic [1:0]        state;
  logic              last_grant;
  logic              gnt;
  logic              win1;
  logic              done;
  logic              abort;
  logic              accept_en;
  logic              accept;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Round-robin: on a tie the requester that did not win last time goes next.
  always_comb begin
    win1       = req1_valid & (~req0_valid | ~last_grant);
    done       = (state == ACCESS) & pready;
    accept_en  = (state == IDLE) | done;
    accept     = accept_en & (req0_valid | req1_valid);
    req0_ready = accept & ~win1;
    req1_ready = accept & win1;
    sel_write  = win1 ? req1_write : req0_write;
    sel_addr   = win1 ? req1_addr  : req0_addr;
    sel_wdata  = win1 ? req1_wdata : req0_wdata;
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SETUP;
            psel       <= 1'b1;
            penable    <= 1'b0;
            pwrite     <= sel_write;
            paddr      <= sel_addr;
            pwdata     <= sel_wdata;
            gnt        <= win1;
            last_grant <= win1;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (done) begin
            if (gnt) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= pwrite ? '0 : prdata;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= pwrite ? '0 : prdata;
            end
            // Back-to-back: a new winner goes straight to SETUP with psel held.
            if (accept) begin
              state      <= SETUP;
              penable    <= 1'b0;
              pwrite     <= sel_write;
              paddr      <= sel_addr;
              pwdata     <= sel_wdata;
              gnt        <= win1;
              last_grant <= win1;
            end else begin
              state   <= IDLE;
              psel    <= 1'b0;
              penable <= 1'b0;
            end
          end else if (abort) begin
            if (gnt) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= '0;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= '0;
            end
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] wait_cnt;

  assign abort = (state == ACCESS) & ~pready & (wait_cnt == TO_LAST);

  // Counter restarts in SETUP so every ACCESS phase begins at zero.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      wait_cnt <= '0;
      rsp0_err <= 1'b0;
      rsp1_err <= 1'b0;
    end else begin
      rsp0_err <= abort & ~gnt;
      rsp1_err <= abort & gnt;
      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !pready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign abort    = 1'b0;
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed table-driven bench for apb_master_arb plus hand-written reset,
// round-robin back-to-back and (when APB_TIMEOUT_EN is defined) timeout sequences.
module tb_apb_master_arb;

  logic        pclk;
  logic        prst;
  logic        req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
  logic [5:0]  req0_addr;
  logic [31:0] req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
  logic [5:0]  req1_addr;
  logic [31:0] req1_wdata, rsp1_rdata;
  logic        psel, penable, pwrite, pready;
  logic [5:0]  paddr;
  logic [31:0] pwdata, prdata;

  int total = 0;
  int bad   = 0;

  apb_master_arb dut (
    .pclk(pclk), .prst(prst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        r0v;
    logic        r0w;
    logic [5:0]  r0a;
    logic [31:0] r0d;
    logic        r1v;
    logic        r1w;
    logic [5:0]  r1a;
    logic [31:0] r1d;
    logic        prdy;
    logic [31:0] prd;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_psel;
    logic        e_pen;
    logic        e_pwr;
    logic [5:0]  e_paddr;
    logic [31:0] e_pwd;
    logic        e_v0;
    logic [31:0] e_rd0;
    logic        e_v1;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    req0_valid = v.r0v; req0_write = v.r0w; req0_addr = v.r0a; req0_wdata = v.r0d;
    req1_valid = v.r1v; req1_write = v.r1w; req1_addr = v.r1a; req1_wdata = v.r1d;
    pready = v.prdy; prdata = v.prd;
    #1;
    chk("req0_ready", idx, 32'(req0_ready), 32'(v.e_rdy0));
    chk("req1_ready", idx, 32'(req1_ready), 32'(v.e_rdy1));
    tick();
    chk("psel", idx, 32'(psel), 32'(v.e_psel));
    chk("penable", idx, 32'(penable), 32'(v.e_pen));
    chk("pwrite", idx, 32'(pwrite), 32'(v.e_pwr));
    chk("paddr", idx, 32'(paddr), 32'(v.e_paddr));
    chk("pwdata", idx, pwdata, v.e_pwd);
    chk("rsp0_valid", idx, 32'(rsp0_valid), 32'(v.e_v0));
    chk("rsp0_rdata", idx, rsp0_rdata, v.e_rd0);
    chk("rsp1_valid", idx, 32'(rsp1_valid), 32'(v.e_v1));
    chk("rsp1_rdata", idx, rsp1_rdata, v.e_rd1);
    chk("rsp0_err", idx, 32'(rsp0_err), 32'd0);
    chk("rsp1_err", idx, 32'(rsp1_err), 32'd0);
  endtask

  initial begin
    // r0v r0w r0a r0d | r1v r1w r1a r1d | prdy prd || rdy0 rdy1 psel pen pwr paddr pwd v0 rd0 v1 rd1
    // single write from requester 0
    tbl.push_back('{1'b1,1'b1,6'h05,32'hDEADBEEF, 1'b0,1'b0,6'h00,32'h0, 1'b1,32'h0,
                    1'b1,1'b0,1'b1,1'b0,1'b1,6'h05,32'hDEADBEEF,1'b0,32'h0,1'b0,32'h0});
    tbl.push_back('{1'b0,1'b1,6'h05,32'hDEADBEEF, 1'b0,1'b0,6'h00,32'h0, 1'b1,32'h0,
                    1'b0,1'b0,1'b1,1'b1,1'b1,6'h05,32'hDEADBEEF,1'b0,32'h0,1'b0,32'h0});
    tbl.push_back('{1'b0,1'b1,6'h05,32'hDEADBEEF, 1'b0,1'b0,6'h00,32'h0, 1'b1,32'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b1,6'h05,32'hDEADBEEF,1'b1,32'h0,1'b0,32'h0});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b0,1'b0,6'h00,32'h0, 1'b0,32'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b1,6'h05,32'hDEADBEEF,1'b0,32'h0,1'b0,32'h0});
    // read from requester 1 with three wait states
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b1,1'b0,6'h3F,32'h0, 1'b0,32'h0,
                    1'b0,1'b1,1'b1,1'b0,1'b0,6'h3F,32'h0,1'b0,32'h0,1'b0,32'h0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b0,1'b0,6'h3F,32'h0, 1'b0,32'h0,
                      1'b0,1'b0,1'b1,1'b1,1'b0,6'h3F,32'h0,1'b0,32'h0,1'b0,32'h0});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b0,1'b0,6'h3F,32'h0, 1'b1,32'h12345678,
                    1'b0,1'b0,1'b0,1'b0,1'b0,6'h3F,32'h0,1'b0,32'h0,1'b1,32'h12345678});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b0,1'b0,6'h3F,32'h0, 1'b0,32'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b0,6'h3F,32'h0,1'b0,32'h0,1'b0,32'h12345678});
    // requester 1 alone for three back-to-back reads, then a tie goes to requester 0
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b1,1'b0,6'h10,32'h0, 1'b1,32'h0,
                    1'b0,1'b1,1'b1,1'b0,1'b0,6'h10,32'h0,1'b0,32'h0,1'b0,32'h12345678});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b1,1'b0,6'h10,32'h0, 1'b1,32'h0,
                    1'b0,1'b0,1'b1,1'b1,1'b0,6'h10,32'h0,1'b0,32'h0,1'b0,32'h12345678});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b1,1'b0,6'h10,32'h0, 1'b1,32'hA1,
                    1'b0,1'b1,1'b1,1'b0,1'b0,6'h10,32'h0,1'b0,32'h0,1'b1,32'hA1});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b1,1'b0,6'h10,32'h0, 1'b1,32'h0,
                    1'b0,1'b0,1'b1,1'b1,1'b0,6'h10,32'h0,1'b0,32'h0,1'b0,32'hA1});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b1,1'b0,6'h10,32'h0, 1'b1,32'hA2,
                    1'b0,1'b1,1'b1,1'b0,1'b0,6'h10,32'h0,1'b0,32'h0,1'b1,32'hA2});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b1,1'b0,6'h10,32'h0, 1'b1,32'h0,
                    1'b0,1'b0,1'b1,1'b1,1'b0,6'h10,32'h0,1'b0,32'h0,1'b0,32'hA2});
    tbl.push_back('{1'b1,1'b1,6'h2A,32'hCAFEF00D, 1'b1,1'b0,6'h10,32'h0, 1'b1,32'hA3,
                    1'b1,1'b0,1'b1,1'b0,1'b1,6'h2A,32'hCAFEF00D,1'b0,32'h0,1'b1,32'hA3});
    tbl.push_back('{1'b0,1'b1,6'h2A,32'hCAFEF00D, 1'b1,1'b0,6'h10,32'h0, 1'b1,32'h55,
                    1'b0,1'b0,1'b1,1'b1,1'b1,6'h2A,32'hCAFEF00D,1'b0,32'h0,1'b0,32'hA3});
    tbl.push_back('{1'b0,1'b1,6'h2A,32'hCAFEF00D, 1'b1,1'b0,6'h10,32'h0, 1'b1,32'h55,
                    1'b0,1'b1,1'b1,1'b0,1'b0,6'h10,32'h0,1'b1,32'h0,1'b0,32'hA3});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b0,1'b0,6'h10,32'h0, 1'b1,32'h0,
                    1'b0,1'b0,1'b1,1'b1,1'b0,6'h10,32'h0,1'b0,32'h0,1'b0,32'hA3});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b0,1'b0,6'h10,32'h0, 1'b1,32'h77,
                    1'b0,1'b0,1'b0,1'b0,1'b0,6'h10,32'h0,1'b0,32'h0,1'b1,32'h77});
    tbl.push_back('{1'b0,1'b0,6'h00,32'h0, 1'b0,1'b0,6'h10,32'h0, 1'b0,32'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b0,6'h10,32'h0,1'b0,32'h0,1'b0,32'h77});

    prst = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    pready = 1'b0; prdata = '0;
    #1;
    chk("rst_psel", 0, 32'(psel), 32'd0);
    chk("rst_penable", 0, 32'(penable), 32'd0);
    chk("rst_paddr", 0, 32'(paddr), 32'd0);
    chk("rst_rsp0_valid", 0, 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 0, 32'(rsp1_valid), 32'd0);
    tick();
    tick();
    prst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], i);

    // reset during ACCESS of a requester-0 read: no response, grant pointer restored
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 6'h01; req0_wdata = 32'h0;
    req1_valid = 1'b0; pready = 1'b0;
    #1;
    chk("mid_rdy0", 100, 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    chk("mid_penable", 101, 32'(penable), 32'd1);
    tick();
    #2;
    prst = 1'b1;
    #1;
    chk("arst_psel", 102, 32'(psel), 32'd0);
    chk("arst_penable", 102, 32'(penable), 32'd0);
    chk("arst_paddr", 102, 32'(paddr), 32'd0);
    chk("arst_rsp1_rdata", 102, rsp1_rdata, 32'd0);
    pready = 1'b1;
    tick();
    prst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_rsp0_valid", 103 + i, 32'(rsp0_valid), 32'd0);
      chk("post_rst_psel", 103 + i, 32'(psel), 32'd0);
    end

    // both requesters continuously valid: alternating grants with psel held high
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 6'h0A;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 6'h0B;
    pready = 1'b1; prdata = 32'h0;
    #1;
    chk("rr_first_rdy0", 110, 32'(req0_ready), 32'd1);
    chk("rr_first_rdy1", 110, 32'(req1_ready), 32'd0);
    tick();
    chk("rr_first_paddr", 110, 32'(paddr), 32'h0A);
    for (int k = 0; k < 4; k++) begin
      automatic int g = k % 2;
      tick();
      chk("rr_penable", 120 + k, 32'(penable), 32'd1);
      chk("rr_psel", 120 + k, 32'(psel), 32'd1);
      chk("rr_paddr", 120 + k, 32'(paddr), (g == 1) ? 32'h0B : 32'h0A);
      prdata = 32'h100 + 32'(k);
      #1;
      chk("rr_rdy0", 120 + k, 32'(req0_ready), (g == 1) ? 32'd1 : 32'd0);
      chk("rr_rdy1", 120 + k, 32'(req1_ready), (g == 0) ? 32'd1 : 32'd0);
      tick();
      chk("rr_psel_b2b", 120 + k, 32'(psel), 32'd1);
      chk("rr_penable_b2b", 120 + k, 32'(penable), 32'd0);
      chk("rr_rsp0_valid", 120 + k, 32'(rsp0_valid), (g == 0) ? 32'd1 : 32'd0);
      chk("rr_rsp1_valid", 120 + k, 32'(rsp1_valid), (g == 1) ? 32'd1 : 32'd0);
      if (g == 0) chk("rr_rsp0_rdata", 120 + k, rsp0_rdata, 32'h100 + 32'(k));
      else        chk("rr_rsp1_rdata", 120 + k, rsp1_rdata, 32'h100 + 32'(k));
    end
    req0_valid = 1'b0; req1_valid = 1'b0; prdata = 32'h1FF;
    tick();
    tick();
    chk("rr_tail_rsp0_valid", 130, 32'(rsp0_valid), 32'd1);
    chk("rr_tail_rsp0_rdata", 130, rsp0_rdata, 32'h1FF);
    chk("rr_tail_psel", 130, 32'(psel), 32'd0);
    tick();

`ifdef APB_TIMEOUT_EN
    // stuck peripheral: abort after 16 ACCESS cycles with error and zero data
    pready = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 6'h03;
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_penable", 140 + i, 32'(penable), 32'd1);
      chk("to_wait_rsp0_valid", 140 + i, 32'(rsp0_valid), 32'd0);
    end
    tick();
    chk("to_rsp0_valid", 160, 32'(rsp0_valid), 32'd1);
    chk("to_rsp0_err", 160, 32'(rsp0_err), 32'd1);
    chk("to_rsp0_rdata", 160, rsp0_rdata, 32'd0);
    chk("to_psel", 160, 32'(psel), 32'd0);
    chk("to_penable", 160, 32'(penable), 32'd0);
    tick();
    chk("to_after_err", 161, 32'(rsp0_err), 32'd0);
    chk("to_after_valid", 161, 32'(rsp0_valid), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
